// File: rtl/dot_product_mac_16bits_if.sv
// Handshake bundle for dot_product_mac_16bits: vector start, pair input, result output.
interface dot_product_mac_16bits_if;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               overflow;
  logic               busy;

  modport master (
    output start, in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_data, overflow, busy
  );

  modport slave (
    input  start, in_valid, a, b, out_ready,
    output in_ready, out_valid, out_data, overflow, busy
  );
endinterface

// File: rtl/dot_product_mac_16bits.sv
// Sequential Q1.14 dot-product engine with a floor-truncating 16-bit multiplier.
// Optional macro SATURATE_EN clamps out_data on overflow instead of wrapping.

module fixed_width_multiply_16bits (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [15:0] p
);
  logic signed [31:0] full;
  assign full = a * b;
  // Arithmetic shift floors toward -inf; keep the low 16 bits of the Q1.14 result
  assign p = 16'(full >>> 14);
endmodule

module dot_product_mac_16bits #(
  parameter int VEC_LEN = 4,
  parameter int ACC_W   = 24
) (
  input logic                     clk,
  input logic                     rst_n,
  dot_product_mac_16bits_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  localparam logic [7:0]              VEC_LEN_C = 8'(VEC_LEN);
  localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] ACC_MIN   = ACC_W'(-32768);

  state_t                  state, state_nxt;
  logic [7:0]              count;
  logic [1:0]              vld_pipe;
  logic signed [15:0]      a_r, b_r, prod_w, prod;
  logic signed [ACC_W-1:0] acc;
  logic                    in_ready, busy, accept, out_hs, acc_ovf;
  logic                    out_valid, overflow;
  logic signed [15:0]      out_data, res;

  fixed_width_multiply_16bits u_mul (.a(a_r), .b(b_r), .p(prod_w));

  assign accept = bus.in_valid && in_ready;
  assign out_hs = out_valid && bus.out_ready;
  assign acc_ovf = (acc > ACC_MAX) || (acc < ACC_MIN);

`ifdef SATURATE_EN
  assign res = (acc > ACC_MAX) ? 16'sh7fff :
               (acc < ACC_MIN) ? 16'sh8000 : acc[15:0];
`else
  assign res = acc[15:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (bus.start) state_nxt = ACC;
      ACC: begin
        in_ready = (count < VEC_LEN_C);
        if (accept && count == VEC_LEN_C - 8'd1) state_nxt = DRAIN;
      end
      // Operand and product stages must both be empty before acc is final
      DRAIN: if (vld_pipe == 2'b00) state_nxt = DONE;
      DONE:  if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      a_r       <= '0;
      b_r       <= '0;
      prod      <= '0;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) begin
        a_r   <= bus.a;
        b_r   <= bus.b;
        count <= count + 8'd1;
      end
      if (vld_pipe[0]) prod <= prod_w;
      if (vld_pipe[1]) acc <= acc + {{(ACC_W-16){prod[15]}}, prod};
      if (state == IDLE && bus.start) begin
        acc   <= '0;
        count <= '0;
      end
      if (state == DRAIN && state_nxt == DONE) begin
        out_valid <= 1'b1;
        out_data  <= res;
        overflow  <= acc_ovf;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_dot_product_mac_16bits.sv
// Self-checking bench for dot_product_mac_16bits (VEC_LEN=4): table vectors, scoreboard, corner sequences.
module tb_dot_product_mac_16bits;
  localparam int VL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dot_product_mac_16bits_if bus();
  dot_product_mac_16bits #(.VEC_LEN(VL), .ACC_W(24)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic signed [15:0] a[VL];
    logic signed [15:0] b[VL];
    logic signed [15:0] exp_wrap;
    logic signed [15:0] exp_sat;
    logic               exp_ovf;
  } vec_t;

  typedef struct {
    logic signed [15:0] d;
    logic               o;
    string              nm;
  } exp_t;

  vec_t tbl[10];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  time  t_acc;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic signed [15:0] mdl_mul(input logic signed [15:0] a, input logic signed [15:0] b);
    int p;
    p = (int'(a) * int'(b)) >>> 14;
    return 16'(p);
  endfunction

  function automatic vec_t mdl_vec(input vec_t v);
    int s;
    vec_t r;
    r = v;
    s = 0;
    for (int i = 0; i < VL; i++) s += int'(mdl_mul(v.a[i], v.b[i]));
    r.exp_ovf  = (s > 32767) || (s < -32768);
    r.exp_wrap = 16'(s);
    r.exp_sat  = (s > 32767) ? 16'sh7fff : (s < -32768) ? 16'sh8000 : 16'(s);
    return r;
  endfunction

  task automatic push_exp(input vec_t v, input string nm);
    exp_t e;
`ifdef SATURATE_EN
    e.d = v.exp_sat;
`else
    e.d = v.exp_wrap;
`endif
    e.o  = v.exp_ovf;
    e.nm = nm;
    sb.push_back(e);
  endtask

  // Starts a vector and feeds its pairs; returns at the negedge after the last acceptance.
  task automatic run_vec(input vec_t v, input bit toggle, input bit t6, input string nm);
    int guard;
    @(negedge clk);
    bus.start = 1'b1;
    if (t6) begin
      bus.in_valid = 1'b1;
      bus.a = 16'sd16384;
      bus.b = 16'sd16384;
      chk({nm, "_in_ready_idle"}, int'(bus.in_ready), 0);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk({nm, "_busy"}, int'(bus.busy), 1);
    for (int i = 0; i < VL; i++) begin
      if (toggle && i > 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.a = v.a[i];
      bus.b = v.b[i];
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) begin
        chk({nm, "_in_ready_timeout"}, 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
    end
    if (toggle) begin
      for (int j = 0; j < 2; j++) begin
        bus.a = 16'sd16384;
        bus.b = 16'sd16384;
        bus.in_valid = (j == 0);
        chk({nm, "_in_ready_after_last"}, int'(bus.in_ready), 0);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    push_exp(v, nm);
  endtask

  task automatic wait_out(input bit hold_test);
    int   guard;
    exp_t e;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    if (guard >= 40) begin
      chk({e.nm, "_out_valid_timeout"}, 0, 1);
      return;
    end
    chk({e.nm, "_latency"}, int'(($time - t_acc - 5) / 10), 3);
    chk({e.nm, "_data"}, int'(bus.out_data), int'(e.d));
    chk({e.nm, "_ovf"}, int'(bus.overflow), int'(e.o));
    if (hold_test) begin
      for (int c = 0; c < 5; c++) begin
        bus.start = (c == 2);
        @(negedge clk);
        chk({e.nm, "_hold_valid"}, int'(bus.out_valid), 1);
        chk({e.nm, "_hold_data"}, int'(bus.out_data), int'(e.d));
      end
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end else begin
      @(negedge clk);
    end
    chk({e.nm, "_valid_drop"}, int'(bus.out_valid), 0);
    chk({e.nm, "_idle"}, int'(bus.busy), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_in_ready"}, int'(bus.in_ready), 0);
    chk({nm, "_out_valid"}, int'(bus.out_valid), 0);
    chk({nm, "_out_data"}, int'(bus.out_data), 0);
    chk({nm, "_overflow"}, int'(bus.overflow), 0);
    chk({nm, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    vec_t rv;
    tbl[0].a = '{1966, 1966, -1966, 164};   tbl[0].b = '{5571, -5571, 4260, -164};
    tbl[0].exp_wrap = -515;   tbl[0].exp_sat = -515;   tbl[0].exp_ovf = 1'b0;
    tbl[1].a = '{16384, 16384, 16384, 16384}; tbl[1].b = '{16384, 16384, 16384, 16384};
    tbl[1].exp_wrap = 0;      tbl[1].exp_sat = 32767;  tbl[1].exp_ovf = 1'b1;
    tbl[2].a = '{-16384, -16384, -16384, -16384}; tbl[2].b = '{16384, 16384, 16384, 16384};
    tbl[2].exp_wrap = 0;      tbl[2].exp_sat = -32768; tbl[2].exp_ovf = 1'b1;
    tbl[3].a = '{32767, 0, 0, 0};   tbl[3].b = '{16384, 0, 0, 0};
    tbl[3].exp_wrap = 32767;  tbl[3].exp_sat = 32767;  tbl[3].exp_ovf = 1'b0;
    tbl[4].a = '{-32768, 0, 0, 0};  tbl[4].b = '{16384, 0, 0, 0};
    tbl[4].exp_wrap = -32768; tbl[4].exp_sat = -32768; tbl[4].exp_ovf = 1'b0;
    tbl[5].a = '{32767, 1, 0, 0};   tbl[5].b = '{16384, 16384, 0, 0};
    tbl[5].exp_wrap = -32768; tbl[5].exp_sat = 32767;  tbl[5].exp_ovf = 1'b1;
    tbl[6].a = '{-32768, -1, 0, 0}; tbl[6].b = '{16384, 16384, 0, 0};
    tbl[6].exp_wrap = 32767;  tbl[6].exp_sat = -32768; tbl[6].exp_ovf = 1'b1;
    tbl[7].a = '{-32768, -32768, -32768, -32768}; tbl[7].b = '{16384, 16384, 16384, 16384};
    tbl[7].exp_wrap = 0;      tbl[7].exp_sat = -32768; tbl[7].exp_ovf = 1'b1;
    tbl[8].a = '{32767, 32767, 32767, 32767}; tbl[8].b = '{16384, 16384, 16384, 16384};
    tbl[8].exp_wrap = -4;     tbl[8].exp_sat = 32767;  tbl[8].exp_ovf = 1'b1;
    tbl[9].a = '{-1, -1, -1, -1};   tbl[9].b = '{1, 1, 1, 1};
    tbl[9].exp_wrap = -4;     tbl[9].exp_sat = -4;     tbl[9].exp_ovf = 1'b0;

    bus.start = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], 1'b0, 1'b0, $sformatf("tbl%0d", i));
      wait_out(1'b0);
    end

    run_vec(tbl[0], 1'b1, 1'b0, "t3_toggle");
    wait_out(1'b0);

    bus.out_ready = 1'b0;
    run_vec(tbl[0], 1'b0, 1'b0, "t4_hold");
    wait_out(1'b1);
    run_vec(tbl[0], 1'b0, 1'b0, "t4_restart");
    wait_out(1'b0);

    // Abort a vector after two accepted pairs
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = tbl[1].a[i];
      bus.b = tbl[1].b[i];
      if (i < 2) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_async_reset");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      chk("t5_no_stale_result", seen, 0);
    end
    run_vec(tbl[0], 1'b0, 1'b0, "t5_fresh");
    wait_out(1'b0);

    run_vec(tbl[0], 1'b0, 1'b1, "t6_start_valid");
    wait_out(1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < VL; i++) begin
        rv.a[i] = 16'($urandom);
        rv.b[i] = 16'($urandom);
      end
      rv = mdl_vec(rv);
      run_vec(rv, (r % 2) == 1, 1'b0, $sformatf("rand%0d", r));
      wait_out(1'b0);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
